// File: rtl/outer_seq.sv
// rtl/outer_seq.sv - outer-interpreter sequencer: walks the TIB, drives finder/atoi/eforth and compiles into the dictionary
module outer_seq #(
  parameter int TIB = 'h0,
  parameter int MSZ = 8,
  parameter int DSZ = 32,
  parameter int ASZ = 17,
  parameter int LIT = 'h01
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           compile,
  input  logic [ASZ-1:0] tib_end,
  input  logic [ASZ-1:0] here0,
  input  logic [MSZ-1:0] mem,
  output logic           mb_we,
  output logic [ASZ-1:0] mb_ai,
  output logic [MSZ-1:0] mb_vi,
  output logic [ASZ-1:0] aw,
  output logic           fdr_en,
  output logic           a2i_en,
  output logic           exe_en,
  input  logic           fdr_bsy,
  input  logic           a2i_bsy,
  input  logic           exe_bsy,
  input  logic [ASZ-1:0] fdr_ai,
  input  logic [ASZ-1:0] a2i_ai,
  input  logic [ASZ-1:0] exe_ai,
  input  logic           fdr_hit,
  input  logic [ASZ-1:0] fdr_tib,
  input  logic           a2i_err,
  input  logic [DSZ-1:0] a2i_vo,
  output logic [ASZ-1:0] exe_pfa,
  output logic [MSZ-1:0] exe_op,
  output logic           ss_push,
  output logic [DSZ-1:0] ss_vi,
  input  logic           ss_full,
  output logic           bsy,
  output logic           err,
  output logic [ASZ-1:0] here
);

  localparam int NB = DSZ / MSZ;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_FND, S_EXE, S_CMA, S_A2I, S_LIT, S_NUM, S_PSH, S_NXT, S_ERR
  } state_t;

  state_t         state, state_n;
  logic [ASZ-1:0] tib;
  logic           mode;
  logic           first;
  logic [DSZ-1:0] val;
  logic [CW-1:0]  cnt;
  logic           fnd_done, a2i_done, exe_done;

  // A unit's busy is ignored on the entry cycle: it has not yet seen its enable.
  assign fnd_done = !first && !fdr_bsy;
  assign a2i_done = !first && !a2i_bsy;
  assign exe_done = !first && !exe_bsy;

  assign aw  = tib;
  assign err = (state == S_ERR);
  assign bsy = (state != S_IDLE) && (state != S_ERR);

  always_comb begin
    state_n = state;
    fdr_en  = 1'b0;
    a2i_en  = 1'b0;
    exe_en  = 1'b0;
    mb_we   = 1'b0;
    mb_ai   = '0;
    mb_vi   = '0;
    ss_push = 1'b0;
    ss_vi   = '0;
    case (state)
      S_IDLE: if (en) state_n = S_FND;
      S_FND: begin
        fdr_en = 1'b1;
        mb_ai  = fdr_ai;
        if (fnd_done) state_n = !fdr_hit ? S_A2I : (compile ? S_CMA : S_EXE);
      end
      S_EXE: begin
        exe_en = 1'b1;
        mb_ai  = exe_ai;
        if (exe_done) state_n = S_NXT;
      end
      S_CMA: begin
        mb_we   = 1'b1;
        mb_ai   = here;
        mb_vi   = exe_op;
        state_n = S_NXT;
      end
      S_A2I: begin
        a2i_en = 1'b1;
        mb_ai  = a2i_ai;
        if (a2i_done) state_n = a2i_err ? S_ERR : (mode ? S_LIT : S_PSH);
      end
      S_LIT: begin
        mb_we   = 1'b1;
        mb_ai   = here;
        mb_vi   = MSZ'(LIT);
        state_n = S_NUM;
      end
      S_NUM: begin
        mb_we = 1'b1;
        mb_ai = here;
        mb_vi = val[MSZ*cnt +: MSZ];
        if (cnt == CW'(NB-1)) state_n = S_NXT;
      end
      S_PSH: begin
        if (ss_full) begin
          state_n = S_ERR;
        end else begin
          ss_push = 1'b1;
          ss_vi   = a2i_vo;
          state_n = S_NXT;
        end
      end
      S_NXT:   state_n = (tib >= tib_end) ? S_IDLE : S_FND;
      S_ERR:   if (!en) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // Abort: nothing half-done may leave the block once en falls.
    if (!en) begin
      state_n = S_IDLE;
      fdr_en  = 1'b0;
      a2i_en  = 1'b0;
      exe_en  = 1'b0;
      mb_we   = 1'b0;
      ss_push = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      first   <= 1'b0;
      tib     <= ASZ'(TIB);
      here    <= '0;
      mode    <= 1'b0;
      val     <= '0;
      cnt     <= '0;
      exe_pfa <= '0;
      exe_op  <= '0;
    end else begin
      state <= state_n;
      first <= (state_n != state);
      if (state == S_IDLE) begin
        tib  <= ASZ'(TIB);
        here <= here0;
        cnt  <= '0;
      end else if (en) begin
        case (state)
          S_FND: if (fnd_done) begin
            exe_pfa <= fdr_ai;
            exe_op  <= mem;
            tib     <= fdr_tib;
            mode    <= compile;
          end
          S_A2I: if (a2i_done) begin
            tib <= a2i_ai;
            if (mode) val <= a2i_vo;
          end
          S_CMA: here <= here + ASZ'(1);
          S_LIT: begin
            here <= here + ASZ'(1);
            cnt  <= '0;
          end
          S_NUM: begin
            here <= here + ASZ'(1);
            cnt  <= (cnt == CW'(NB-1)) ? '0 : cnt + CW'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_outer_seq.sv
// tb/tb_outer_seq.sv - scoreboard bench for outer_seq with behavioural unit models
module tb_outer_seq;

  localparam int MSZ = 8;
  localparam int DSZ = 32;
  localparam int ASZ = 17;
  localparam int NB  = DSZ / MSZ;

  logic           clk, rst, en, compile;
  logic [ASZ-1:0] tib_end, here0;
  logic [MSZ-1:0] mem;
  logic           mb_we;
  logic [ASZ-1:0] mb_ai;
  logic [MSZ-1:0] mb_vi;
  logic [ASZ-1:0] aw;
  logic           fdr_en, a2i_en, exe_en;
  logic           fdr_bsy, a2i_bsy, exe_bsy;
  logic [ASZ-1:0] fdr_ai, a2i_ai, exe_ai;
  logic           fdr_hit;
  logic [ASZ-1:0] fdr_tib;
  logic           a2i_err;
  logic [DSZ-1:0] a2i_vo;
  logic [ASZ-1:0] exe_pfa;
  logic [MSZ-1:0] exe_op;
  logic           ss_push;
  logic [DSZ-1:0] ss_vi;
  logic           ss_full;
  logic           bsy, err;
  logic [ASZ-1:0] here;

  outer_seq dut (
    .clk(clk), .rst(rst), .en(en), .compile(compile), .tib_end(tib_end), .here0(here0),
    .mem(mem), .mb_we(mb_we), .mb_ai(mb_ai), .mb_vi(mb_vi), .aw(aw),
    .fdr_en(fdr_en), .a2i_en(a2i_en), .exe_en(exe_en),
    .fdr_bsy(fdr_bsy), .a2i_bsy(a2i_bsy), .exe_bsy(exe_bsy),
    .fdr_ai(fdr_ai), .a2i_ai(a2i_ai), .exe_ai(exe_ai),
    .fdr_hit(fdr_hit), .fdr_tib(fdr_tib), .a2i_err(a2i_err), .a2i_vo(a2i_vo),
    .exe_pfa(exe_pfa), .exe_op(exe_op), .ss_push(ss_push), .ss_vi(ss_vi),
    .ss_full(ss_full), .bsy(bsy), .err(err), .here(here)
  );

  typedef struct {
    bit             hit, cmp, aerr, full;
    logic [7:0]     op;
    logic [ASZ-1:0] pfa, ntib;
    logic [31:0]    val;
    int             fb, ab, eb;
  } tok_t;

  typedef struct {
    int          kind;   // 0 write, 1 push, 2 execute
    logic [31:0] a, d;
    int          len;
  } ev_t;

  tok_t           toks[8];
  tok_t           cur;
  int             ti, fc, ac, ec;
  ev_t            exp_q[$];
  logic [ASZ-1:0] exp_here, ma;
  bit             exp_err;
  int             checks, failures, wr_cnt, exe_cnt, exe_len;
  logic           exe_prev;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic unexpected(input string nm, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%0h required=no_event", nm, act);
  endtask

  // Unit models: finder/atoi/eforth respond from the current token; memory returns op at pfa one cycle late.
  initial begin
    fc = 0; ac = 0; ec = 0; ti = 0;
    cur = toks[0];
    forever begin
      @(posedge clk);
      #1;
      if (fdr_en) begin
        if (fc == 0 && ti < 8) begin
          cur = toks[ti];
          ti++;
        end
        fc++;
      end else fc = 0;
      if (a2i_en) ac++; else ac = 0;
      if (exe_en) ec++; else ec = 0;
      mem     = (ma == cur.pfa) ? cur.op : 8'h5A;
      fdr_bsy = fdr_en && (fc <= cur.fb);
      a2i_bsy = a2i_en && (ac <= cur.ab);
      exe_bsy = exe_en && (ec <= cur.eb);
      fdr_ai  = cur.pfa;
      fdr_hit = cur.hit;
      fdr_tib = cur.ntib;
      compile = cur.cmp;
      a2i_ai  = cur.ntib;
      a2i_err = cur.aerr;
      a2i_vo  = cur.val;
      ss_full = cur.full;
      exe_ai  = cur.pfa + 17'd1;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT writes, pushes or starts an execute.
  initial begin
    ev_t e;
    exe_prev = 1'b0; exe_cnt = 0; exe_len = 0; wr_cnt = 0;
    forever begin
      @(negedge clk);
      ma = mb_ai;
      if (mb_we) begin
        wr_cnt++;
        if (exp_q.size() == 0) unexpected("write", {mb_ai, mb_vi});
        else begin
          e = exp_q.pop_front();
          chk("wr_kind", e.kind, 0);
          chk("wr_addr", mb_ai, e.a);
          chk("wr_data", mb_vi, e.d);
        end
      end
      if (ss_push) begin
        if (exp_q.size() == 0) unexpected("push", ss_vi);
        else begin
          e = exp_q.pop_front();
          chk("push_kind", e.kind, 1);
          chk("push_val", ss_vi, e.d);
        end
      end
      if (exe_en && !exe_prev) begin
        exe_cnt = 0;
        if (exp_q.size() == 0) unexpected("exe", exe_pfa);
        else begin
          e = exp_q.pop_front();
          chk("exe_kind", e.kind, 2);
          chk("exe_pfa", exe_pfa, e.a);
          chk("exe_op", exe_op, e.d);
          exe_len = e.len;
        end
      end
      if (exe_en) exe_cnt++;
      if (!exe_en && exe_prev) chk("exe_len", exe_cnt, exe_len);
      exe_prev = exe_en;
    end
  end

  // Reference: what the dictionary, stack and eforth must see for a token list.
  task automatic model(input int n, input logic [ASZ-1:0] h0, input logic [ASZ-1:0] tend);
    logic [ASZ-1:0] h;
    h = h0;
    exp_err = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (toks[i].hit) begin
        if (toks[i].cmp) begin
          exp_q.push_back('{0, 32'(h), 32'(toks[i].op), 0});
          h = h + 1'b1;
        end else begin
          exp_q.push_back('{2, 32'(toks[i].pfa), 32'(toks[i].op),
                            (toks[i].eb + 1 > 2) ? toks[i].eb + 1 : 2});
        end
      end else if (toks[i].aerr) begin
        exp_err = 1'b1;
        break;
      end else if (toks[i].cmp) begin
        exp_q.push_back('{0, 32'(h), 32'h01, 0});
        h = h + 1'b1;
        for (int k = 0; k < NB; k++) begin
          exp_q.push_back('{0, 32'(h), (toks[i].val >> (8 * k)) & 32'hFF, 0});
          h = h + 1'b1;
        end
      end else if (toks[i].full) begin
        exp_err = 1'b1;
        break;
      end else begin
        exp_q.push_back('{1, 32'(0), toks[i].val, 0});
      end
      if (toks[i].ntib >= tend) break;
    end
    exp_here = h;
  endtask

  task automatic set_tok(input int i, input bit hit, input bit cmp, input logic [7:0] op,
                         input logic [ASZ-1:0] pfa, input logic [ASZ-1:0] ntib,
                         input logic [31:0] val, input bit aerr, input bit full,
                         input int fb, input int ab, input int eb);
    toks[i].hit = hit;   toks[i].cmp = cmp;   toks[i].op = op;
    toks[i].pfa = pfa;   toks[i].ntib = ntib; toks[i].val = val;
    toks[i].aerr = aerr; toks[i].full = full;
    toks[i].fb = fb;     toks[i].ab = ab;     toks[i].eb = eb;
  endtask

  task automatic run(input string nm, input int n, input logic [ASZ-1:0] h0,
                     input logic [ASZ-1:0] tend);
    int k;
    here0 = h0;
    tib_end = tend;
    ti = 0;
    model(n, h0, tend);
    @(posedge clk);
    #1 en = 1'b1;
    k = 0;
    while (!bsy && k < 10) begin @(negedge clk); k++; end
    chk({nm, "_start"}, bsy, 1);
    k = 0;
    while (bsy && k < 3000) begin @(negedge clk); k++; end
    chk({nm, "_end_bsy"}, bsy, 0);
    chk({nm, "_here"}, here, exp_here);
    chk({nm, "_err"}, err, exp_err);
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk({nm, "_err_clr"}, err, 0);
    chk({nm, "_q_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int n;
    logic [ASZ-1:0] pos, tend;
    checks = 0; failures = 0;
    rst = 1'b0; en = 1'b0; tib_end = '0; here0 = '0; ma = '0;
    for (int i = 0; i < 8; i++) set_tok(i, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_bsy", bsy, 0);
    chk("rst_err", err, 0);
    chk("rst_en", {fdr_en, a2i_en, exe_en, mb_we, ss_push}, 0);
    chk("rst_bus", {mb_ai, mb_vi}, 0);
    chk("rst_exe", {exe_pfa, exe_op}, 0);
    chk("rst_tib_here", {aw, here}, 0);
    rst = 1'b1;

    set_tok(0, 1, 0, 8'h22, 17'h0120, 17'd4, 0, 0, 0, 1, 0, 3);
    run("dup", 1, 17'h0, 17'd4);
    set_tok(0, 0, 0, 0, 17'h0033, 17'd4, 32'd123, 0, 0, 0, 2, 0);
    run("push123", 1, 17'h0, 17'd4);
    set_tok(0, 0, 1, 0, 17'h0033, 17'd4, 32'd123, 0, 0, 2, 1, 0);
    run("comp123", 1, 17'h400, 17'd4);
    set_tok(0, 1, 1, 8'h22, 17'h0120, 17'd4, 0, 0, 0, 0, 0, 0);
    run("comp_hit", 1, 17'h400, 17'd4);
    set_tok(0, 0, 1, 0, 17'h0033, 17'd4, 32'hCAFE, 1, 0, 0, 1, 0);
    run("a2i_err", 1, 17'h400, 17'd4);
    set_tok(0, 0, 0, 0, 17'h0033, 17'd4, 32'd77, 0, 1, 0, 0, 0);
    run("ss_full", 1, 17'h400, 17'd4);
    set_tok(0, 0, 1, 0, 17'h0033, 17'd3, 32'h89ABCDEF, 0, 0, 0, 0, 0);
    run("wrap", 1, 17'h1FFFE, 17'd3);
    set_tok(0, 1, 0, 8'h40, 17'h0200, 17'd3, 0, 0, 0, 0, 0, 0);
    set_tok(1, 1, 0, 8'h41, 17'h0210, 17'd6, 0, 0, 0, 0, 0, 0);
    run("end_le_tib", 2, 17'h0, 17'h0);

    for (int r = 0; r < 40; r++) begin
      n = $urandom_range(1, 5);
      pos = '0;
      for (int i = 0; i < n; i++) begin
        pos = pos + ASZ'($urandom_range(1, 8));
        set_tok(i, 1'($urandom), 1'($urandom), 8'($urandom), ASZ'($urandom), pos, $urandom,
                $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end
      tend = ($urandom_range(0, 7) == 0) ? '0 : pos;
      run("rand", n, ASZ'($urandom), tend);
    end

    // Abort in NUM once the opcode and two value bytes are out.
    set_tok(0, 0, 1, 0, 17'h0033, 17'd4, 32'hA1B2C3D4, 0, 0, 0, 0, 0);
    exp_q.push_back('{0, 32'h200, 32'h01, 0});
    exp_q.push_back('{0, 32'h201, 32'hD4, 0});
    exp_q.push_back('{0, 32'h202, 32'hC3, 0});
    here0 = 17'h200; tib_end = 17'd4; ti = 0; wr_cnt = 0;
    @(posedge clk);
    #1 en = 1'b1;
    for (int k = 0; k < 50 && wr_cnt < 3; k++) @(negedge clk);
    chk("abort_writes_seen", wr_cnt, 3);
    @(posedge clk);
    #1 chk("abort_we_before", mb_we, 1);
    en = 1'b0;
    #1 chk("abort_we_drop", mb_we, 0);
    @(posedge clk);
    #1 chk("abort_idle", bsy, 0);
    @(negedge clk);
    chk("abort_wr_cnt", wr_cnt, 3);
    chk("abort_q_empty", exp_q.size(), 0);

    // Asynchronous reset while the finder is busy.
    set_tok(0, 1, 0, 8'h22, 17'h0120, 17'd4, 0, 0, 0, 6, 0, 0);
    here0 = 17'h123; ti = 0;
    @(posedge clk);
    #1 en = 1'b1;
    for (int k = 0; k < 10 && !fdr_en; k++) @(negedge clk);
    chk("rstp_in_fnd", fdr_en, 1);
    #2 rst = 1'b0;
    #1;
    chk("rstp_en", {fdr_en, a2i_en, exe_en, mb_we, ss_push}, 0);
    chk("rstp_bsy_err", {bsy, err}, 0);
    chk("rstp_here_tib", {here, aw}, 0);
    chk("rstp_exe", {exe_pfa, exe_op}, 0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rstp_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
